// File: rtl/hazard_scoreboard_if.sv
// Decoder <-> hazard scoreboard interface.
// master: ID-stage decoder (drives instruction info, observes stall/status).
// slave : hazard_scoreboard.
interface hazard_scoreboard_if #(
  parameter int REG_BITS = 5,
  parameter int CNT_W    = 32
);
  logic                     issue_valid;
  logic [REG_BITS-1:0]      rs;
  logic [REG_BITS-1:0]      rt;
  logic                     rs_used;
  logic                     rt_used;
  logic [REG_BITS-1:0]      dest;
  logic                     dest_we;
  logic                     flush;
  logic                     all_buf_req;
  logic                     all_buf_flags;
  logic                     stall;
  logic [(1<<REG_BITS)-1:0] busy_vec;
  logic                     timeout_err;
  logic [CNT_W-1:0]         stall_count;

  modport master (
    output issue_valid, rs, rt, rs_used, rt_used, dest, dest_we, flush,
           all_buf_req, all_buf_flags,
    input  stall, busy_vec, timeout_err, stall_count
  );

  modport slave (
    input  issue_valid, rs, rt, rs_used, rt_used, dest, dest_we, flush,
           all_buf_req, all_buf_flags,
    output stall, busy_vec, timeout_err, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage RAW hazard detector built on a PIPE_DEPTH-deep
// tag pipeline of in-flight register writes. Also handles squash-on-flush,
// the all-SAD-buffer wait with sticky timeout, and a saturating stall counter.
// Optional feature macro: WB_BYPASS_EN -- when defined, the write-back entry
// (last pipe stage) is excluded from matching because the register file
// writes in the first half-cycle; requires PIPE_DEPTH >= 2.
module hazard_scoreboard #(
  parameter int PIPE_DEPTH = 3,
  parameter int REG_BITS   = 5,
  parameter int TIMEOUT    = 255,
  parameter int CNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  hazard_scoreboard_if.slave sb
);

  localparam int NREGS = 1 << REG_BITS;
`ifdef WB_BYPASS_EN
  localparam int MATCH_N = PIPE_DEPTH - 1;
`else
  localparam int MATCH_N = PIPE_DEPTH;
`endif
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  // Tag pipeline: entry 0 is EX, entry PIPE_DEPTH-1 is the write-back stage.
  logic [PIPE_DEPTH-1:0] valid_reg;
  logic [REG_BITS-1:0]   tag_reg [PIPE_DEPTH];

  logic [NREGS-1:0]  busy_vec_c;
  logic              raw_rs;
  logic              raw_rt;
  logic              buf_wait;
  logic              stall_c;
  logic              insert_c;
  logic              wait_active;

  logic [15:0]       wait_cnt_reg;
  logic [15:0]       wait_cnt_next;
  logic              timeout_err_reg;
  logic              timeout_err_next;
  logic [CNT_W-1:0]  stall_count_reg;
  logic [CNT_W-1:0]  stall_count_next;

  // Per-register pending mask; register 0 is hardwired zero and never busy.
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy_vec_c[gi] = 1'b0;
      end else begin : g_reg
        logic hit;
        // OR of every valid in-range entry whose tag names this register.
        always_comb begin
          hit = 1'b0;
          for (int i = 0; i < MATCH_N; i++) begin
            if (valid_reg[i] && (tag_reg[i] == REG_BITS'(gi))) hit = 1'b1;
          end
        end
        assign busy_vec_c[gi] = hit;
      end
    end
  endgenerate

  // Same-cycle hazard and stall decision, plus the insert qualifier for EX.
  always_comb begin
    raw_rs      = sb.rs_used & (sb.rs != '0) & busy_vec_c[sb.rs];
    raw_rt      = sb.rt_used & (sb.rt != '0) & busy_vec_c[sb.rt];
    buf_wait    = sb.all_buf_req & ~sb.all_buf_flags;
    stall_c     = sb.issue_valid & ~sb.flush & (raw_rs | raw_rt | buf_wait);
    insert_c    = sb.issue_valid & ~stall_c & ~sb.flush & sb.dest_we & (sb.dest != '0);
    wait_active = buf_wait & sb.issue_valid & ~sb.flush;
  end

  // Next-state for the wait counter, sticky timeout flag and stall counter.
  always_comb begin
    wait_cnt_next = 16'd0;
    if (wait_active) begin
      wait_cnt_next = (wait_cnt_reg == TIMEOUT_C) ? wait_cnt_reg : wait_cnt_reg + 16'd1;
    end
    timeout_err_next = timeout_err_reg | (wait_active & (wait_cnt_next == TIMEOUT_C));
    stall_count_next = stall_count_reg;
    if (stall_c && !(&stall_count_reg)) stall_count_next = stall_count_reg + CNT_W'(1);
  end

  // Advance the tag pipe every clock; a stalled/flushed/non-writing slot is a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) tag_reg[i] <= '0;
    end else begin
      valid_reg[0] <= insert_c;
      tag_reg[0]   <= sb.dest;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        valid_reg[i] <= valid_reg[i-1];
        tag_reg[i]   <= tag_reg[i-1];
      end
    end
  end

  // Status registers: wait counter, sticky timeout, saturating stall count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_reg    <= 16'd0;
      timeout_err_reg <= 1'b0;
      stall_count_reg <= '0;
    end else begin
      wait_cnt_reg    <= wait_cnt_next;
      timeout_err_reg <= timeout_err_next;
      stall_count_reg <= stall_count_next;
    end
  end

  assign sb.stall       = stall_c;
  assign sb.busy_vec    = busy_vec_c;
  assign sb.timeout_err = timeout_err_reg;
  assign sb.stall_count = stall_count_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard (PIPE_DEPTH=3, TIMEOUT=4).
// The driver pushes the expected outputs for every driven cycle; a monitor
// pops and compares them on the falling edge. Build with or without
// WB_BYPASS_EN; expectations adapt.
module tb_hazard_scoreboard;

`ifdef WB_BYPASS_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  typedef struct {
    string       nm;
    logic        stall;
    logic [31:0] busy;
    logic        terr;
    logic [31:0] cnt;
  } exp_t;

  logic clk;
  logic rst;
  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   exp_cnt  = 0;
  bit   exp_terr = 1'b0;

  hazard_scoreboard_if #(.REG_BITS(5), .CNT_W(32)) sb_if ();

  hazard_scoreboard #(
    .PIPE_DEPTH(3),
    .REG_BITS  (5),
    .TIMEOUT   (4),
    .CNT_W     (32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sb (sb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] m(input int r);
    logic [31:0] one;
    one = 32'd1;
    return one << r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input string nm, input bit iv, input int rs, input bit rsu,
                     input int rt, input bit rtu, input int dst, input bit we,
                     input bit fl, input bit req, input bit flg,
                     input bit es, input logic [31:0] eb);
    exp_t e;
    @(posedge clk);
    #1;
    sb_if.issue_valid   = iv;
    sb_if.rs            = 5'(rs);
    sb_if.rs_used       = rsu;
    sb_if.rt            = 5'(rt);
    sb_if.rt_used       = rtu;
    sb_if.dest          = 5'(dst);
    sb_if.dest_we       = we;
    sb_if.flush         = fl;
    sb_if.all_buf_req   = req;
    sb_if.all_buf_flags = flg;
    e.nm = nm; e.stall = es; e.busy = eb; e.terr = exp_terr; e.cnt = 32'(exp_cnt);
    q.push_back(e);
    if (es) exp_cnt++;
  endtask

  // Monitor: compare every presented cycle against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({e.nm, ".stall"}, 32'(sb_if.stall), 32'(e.stall));
      chk({e.nm, ".busy"}, sb_if.busy_vec, e.busy);
      chk({e.nm, ".terr"}, 32'(sb_if.timeout_err), 32'(e.terr));
      chk({e.nm, ".cnt"}, sb_if.stall_count, e.cnt);
      $display("cycle %s stall=%0b busy=%08h terr=%0b cnt=%0d",
               e.nm, sb_if.stall, sb_if.busy_vec, sb_if.timeout_err, sb_if.stall_count);
    end
  end

  initial begin
    rst = 1'b1;
    sb_if.issue_valid = 0; sb_if.rs = 0; sb_if.rs_used = 0; sb_if.rt = 0;
    sb_if.rt_used = 0; sb_if.dest = 0; sb_if.dest_we = 0; sb_if.flush = 0;
    sb_if.all_buf_req = 0; sb_if.all_buf_flags = 0;
    #2;
    chk("reset.stall", 32'(sb_if.stall), 32'd0);
    chk("reset.busy", sb_if.busy_vec, 32'd0);
    chk("reset.terr", 32'(sb_if.timeout_err), 32'd0);
    chk("reset.cnt", sb_if.stall_count, 32'd0);
    #10 rst = 1'b0;

    // RAW on rs: 3 stall cycles (2 with bypass)
    cyc("s1_wr",  1, 0,0, 0,0, 8,1, 0, 0,0, 0, 0);
    cyc("s1_rd1", 1, 8,1, 0,0, 0,0, 0, 0,0, 1, m(8));
    cyc("s1_rd2", 1, 8,1, 0,0, 0,0, 0, 0,0, 1, m(8));
    cyc("s1_rd3", 1, 8,1, 0,0, 0,0, 0, 0,0, !BP, BP ? 32'd0 : m(8));
    cyc("s1_rd4", 1, 8,1, 0,0, 0,0, 0, 0,0, 0, 0);
    // Writes to r0 never tracked
    cyc("s2_wr",  1, 0,0, 0,0, 0,1, 0, 0,0, 0, 0);
    cyc("s2_rd",  1, 0,1, 0,1, 0,0, 0, 0,0, 0, 0);
    // Flushed writer never inserted
    cyc("s3_wrfl",1, 0,0, 0,0, 9,1, 1, 0,0, 0, 0);
    cyc("s3_rd",  1, 0,0, 9,1, 0,0, 0, 0,0, 0, 0);
    // Unused sources do not stall
    cyc("u_wr",   1, 0,0, 0,0, 12,1, 0, 0,0, 0, 0);
    cyc("u_rd",   1, 12,0, 12,0, 0,0, 0, 0,0, 0, m(12));
    cyc("u_idle1",0, 0,0, 0,0, 0,0, 0, 0,0, 0, m(12));
    cyc("u_idle2",0, 0,0, 0,0, 0,0, 0, 0,0, 0, BP ? 32'd0 : m(12));
    // Flush forces stall low; older entry kept
    cyc("f_wr",   1, 0,0, 0,0, 10,1, 0, 0,0, 0, 0);
    cyc("f_rdfl", 1, 10,1, 0,0, 0,0, 1, 0,0, 0, m(10));
    cyc("f_idle1",0, 0,0, 0,0, 0,0, 0, 0,0, 0, m(10));
    cyc("f_idle2",0, 0,0, 0,0, 0,0, 0, 0,0, 0, BP ? 32'd0 : m(10));
    // Two writers of r5, rt reader
    cyc("d_wr1",  1, 0,0, 0,0, 5,1, 0, 0,0, 0, 0);
    cyc("d_wr2",  1, 0,0, 0,0, 5,1, 0, 0,0, 0, m(5));
    cyc("d_rd1",  1, 0,0, 5,1, 0,0, 0, 0,0, 1, m(5));
    cyc("d_rd2",  1, 0,0, 5,1, 0,0, 0, 0,0, 1, m(5));
    cyc("d_rd3",  1, 0,0, 5,1, 0,0, 0, 0,0, !BP, BP ? 32'd0 : m(5));
    cyc("d_rd4",  1, 0,0, 5,1, 0,0, 0, 0,0, 0, 0);
    // RAW plus buffer wait: one stall per cycle
    cyc("c_wr",   1, 0,0, 0,0, 7,1, 0, 0,0, 0, 0);
    cyc("c_rd1",  1, 7,1, 0,0, 0,0, 0, 1,0, 1, m(7));
    cyc("c_rd2",  1, 7,1, 0,0, 0,0, 0, 1,0, 1, m(7));
    cyc("c_rd3",  1, 7,1, 0,0, 0,0, 0, 1,1, !BP, BP ? 32'd0 : m(7));
    cyc("c_idle", 0, 0,0, 0,0, 0,0, 0, 0,0, 0, 0);
    // Flush clears the wait counter: 3 + 3 waits never time out
    for (int k = 0; k < 3; k++) cyc("w_a", 1, 0,0, 0,0, 0,0, 0, 1,0, 1, 0);
    cyc("w_flush",1, 0,0, 0,0, 0,0, 1, 1,0, 0, 0);
    for (int k = 0; k < 3; k++) cyc("w_b", 1, 0,0, 0,0, 0,0, 0, 1,0, 1, 0);
    cyc("w_done", 1, 0,0, 0,0, 0,0, 0, 1,1, 0, 0);
    // Six waits with TIMEOUT=4: flag visible after the 4th
    for (int k = 1; k <= 6; k++) begin
      exp_terr = (k >= 5);
      cyc("t_wait", 1, 0,0, 0,0, 0,0, 0, 1,0, 1, 0);
    end
    cyc("t_rel",  1, 0,0, 0,0, 0,0, 0, 1,1, 0, 0);
    cyc("t_noiv", 0, 0,0, 0,0, 0,0, 0, 1,0, 0, 0);
    // Asynchronous reset in the middle of a RAW stall
    cyc("r_wr",   1, 0,0, 0,0, 8,1, 0, 0,0, 0, 0);
    @(posedge clk);
    #1;
    sb_if.rs = 5'd8; sb_if.rs_used = 1; sb_if.dest = 0; sb_if.dest_we = 0;
    sb_if.all_buf_req = 0; sb_if.all_buf_flags = 0;
    #1;
    chk("r_pre.stall", 32'(sb_if.stall), 32'd1);
    chk("r_pre.terr", 32'(sb_if.timeout_err), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("r_async.stall", 32'(sb_if.stall), 32'd0);
    chk("r_async.busy", sb_if.busy_vec, 32'd0);
    chk("r_async.terr", 32'(sb_if.timeout_err), 32'd0);
    chk("r_async.cnt", sb_if.stall_count, 32'd0);
    exp_cnt = 0;
    exp_terr = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    cyc("r_after",1, 8,1, 0,0, 0,0, 0, 0,0, 0, 0);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    chk("drain.qsize", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
